// File: rtl/dispatch_ctrl.sv
// Instruction queue between fetch and decode: buffers instr/PC pairs and
// issues the head when the ROB and the target unit (RS or LSB) have room.
module dispatch_ctrl #(
    parameter int IQ_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_fetch_valid,
    input  logic [31:0]      in_fetch_instr,
    input  logic [31:0]      in_fetch_pc,
    output logic             out_fetch_ready,
    input  logic             in_flush,
    input  logic             in_rob_full,
    input  logic             in_rs_full,
    input  logic             in_lsb_full,
    output logic             out_dec_valid,
    output logic [31:0]      out_dec_instr,
    output logic [31:0]      out_dec_pc,
    output logic             out_dispatch,
    output logic [1:0]       out_unit,
    output logic [CNT_W-1:0] out_occupancy,
    output logic [31:0]      out_stall_cycles
);

    localparam int PTR_W = $clog2(IQ_DEPTH);

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_RS   = 2'd1,
        UNIT_LSB  = 2'd2,
        UNIT_ILL  = 2'd3
    } unit_e;

    logic [31:0]      mem_instr [IQ_DEPTH];
    logic [31:0]      mem_pc    [IQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      stall_cnt;

    logic [31:0] head_instr;
    logic        active;
    logic        push;
    logic        pop;
    logic        stall_inc;
    unit_e       unit;

    assign head_instr = mem_instr[head];
    assign active     = rst & rdy & ~in_flush;

    always_comb begin
        unit = UNIT_NONE;
        if (count != '0) begin
            case (head_instr[6:0])
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0010011, 7'b0110011: unit = UNIT_RS;
                7'b0000011, 7'b0100011:             unit = UNIT_LSB;
                default:                            unit = UNIT_ILL;
            endcase
        end
    end

    // Ready looks only at current occupancy, never at a same-cycle pop.
    assign out_fetch_ready = active & (count < CNT_W'(IQ_DEPTH));
    assign push            = in_fetch_valid & out_fetch_ready;

    assign out_dispatch = active & out_dec_valid & ~in_rob_full &
                          (((unit == UNIT_RS)  & ~in_rs_full) |
                           ((unit == UNIT_LSB) & ~in_lsb_full));
    assign pop          = out_dispatch | (active & (unit == UNIT_ILL));
    assign stall_inc    = active & ((unit == UNIT_RS) | (unit == UNIT_LSB)) & ~out_dispatch;

    assign out_dec_valid    = (count != '0);
    assign out_dec_instr    = out_dec_valid ? head_instr : 32'd0;
    assign out_dec_pc       = out_dec_valid ? mem_pc[head] : 32'd0;
    assign out_unit         = unit;
    assign out_occupancy    = count;
    assign out_stall_cycles = stall_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail] <= in_fetch_instr;
            mem_pc[tail]    <= in_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            // Stall history survives flushes; only reset clears it.
            if (stall_inc && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Instruction queue and dispatch scheduler between the fetcher and the decoder. Buffers fetched instruction/PC pairs in a small FIFO and presents the head to decode. Decides each cycle whether the head can issue, based on ROB, RS and LSB availability and the head's class. Pops the head on issue, and clears everything on a misprediction flush.

## Interface
Parameters:
- IQ_DEPTH, 4: queue entries; power of two, ≥2.
- CNT_W, 3: occupancy width, = log2(IQ_DEPTH)+1.

Ports:
- clk  in  1  the one clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global ready; when 0, all state holds and out_dispatch=0.
- in_fetch_valid  in  1  fetcher offers an instruction.
- in_fetch_instr  in  32  instruction word.
- in_fetch_pc  in  32  its PC.
- out_fetch_ready  out  1  queue accepts a push this cycle.
- in_flush  in  1  misprediction flush from ROB.
- in_rob_full  in  1  ROB cannot allocate this cycle.
- in_rs_full  in  1  RS cannot accept this cycle.
- in_lsb_full  in  1  LSB cannot accept this cycle.
- out_dec_valid  out  1  head entry valid.
- out_dec_instr  out  32  head instruction, to decode.
- out_dec_pc  out  32  head PC, to decode.
- out_dispatch  out  1  head issues this cycle; ROB/RS/LSB latch decode outputs at this edge.
- out_unit  out  2  head class: 0 none, 1 RS, 2 LSB, 3 illegal.
- out_occupancy  out  CNT_W  entries held.
- out_stall_cycles  out  32  saturating structural-stall counter.

## Operation
Storage:
- Circular buffer with head pointer, tail pointer and count.
- Pointers are log2(IQ_DEPTH) bits and wrap modulo IQ_DEPTH.

Classification of the head, by opcode [6:0]:
- RS: 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011.
- LSB: 0000011, 0100011.
- Illegal: any other opcode.
- None: queue empty.

Push and pop:
- push = in_fetch_valid & out_fetch_ready.
- out_fetch_ready = rst & rdy & ~in_flush & (count < IQ_DEPTH).
- Ready never depends on a same-cycle pop, so a full queue refuses a push even when popping.
- out_dispatch = rst & rdy & ~in_flush & out_dec_valid & ~in_rob_full & ((unit==RS & ~in_rs_full) | (unit==LSB & ~in_lsb_full)).
- pop = out_dispatch, or an illegal head. An illegal head is dropped silently with out_dispatch=0, still subject to rst, rdy and ~in_flush.
- Push and pop in the same cycle leave count unchanged; both pointers advance.

Flush:
- in_flush=1 (with rdy=1) sets head, tail and count to 0.
- Any push or pop in that cycle is discarded.

Stall counter:
- Increments when rdy, ~in_flush, the head is RS or LSB class, and out_dispatch=0.
- Saturates at 32'hFFFFFFFF.
- Is not cleared by flush.

Reset and outputs:
- rst=0 at an edge: head, tail and count to 0, stall counter to 0.
- While rst=0: out_fetch_ready=0 and out_dispatch=0.
- out_dec_valid = (count≠0). out_dec_instr/pc are the head entry, or 0 when empty.
- out_occupancy = count.

## Timing
- All outputs are combinational from state and current inputs. There is no comb path from in_fetch_valid to any output.
- Push accepted at edge N: entry visible at the head from cycle N+1. There is no empty-queue bypass, so fetch-to-dispatch minimum latency is 1 cycle.
- Dispatch/pop at edge N: the next entry is at the head in cycle N+1. Sustained throughput is 1 per cycle.
- After a full drain, the queue accepts again in the next cycle.
- After reset deassertion: out_fetch_ready=1, out_dec_valid=0, out_unit=0, out_occupancy=0, out_stall_cycles=0.
- rdy=0: state frozen and outputs reflect the held state. out_fetch_ready and out_dispatch are both 0.
- Flush and reset are both synchronous. rst=0 has priority over in_flush. Reset mid-stream discards all entries.

## Test plan
- Reset then push ADDI 0x00100093 at pc 0x0 with rs/rob/lsb not full: cycle+1 out_dec_valid=1, out_unit=1, out_dispatch=1; next cycle occupancy 0.
- Hold in_rob_full=1, push 5 instructions with IQ_DEPTH=4: 4 accepted, out_fetch_ready=0 on the 5th, occupancy=4, out_stall_cycles increments by 1 per blocked cycle.
- Head LW 0x00002083 with in_lsb_full=1, in_rs_full=0: out_unit=2, out_dispatch=0. Release lsb_full: dispatch next cycle.
- Queue holds 3 entries, assert in_flush with in_fetch_valid=1: next cycle occupancy=0, out_dec_valid=0, the pushed entry is absent.
- Push 0xFFFFFFFF (illegal) then ADD 0x002081B3: illegal is dropped with out_dispatch=0 and out_unit=3, then ADD dispatches one cycle later. Check wrap after 8 pushes/pops with pcs 0x0–0x1C kept in order.
- rdy=0 for 3 cycles with 2 entries queued: occupancy stays 2, no dispatch, stall counter unchanged.
